// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer:
// the adder slice width and the control FSM state encoding.
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_add_ctrl_add4_ci.sv
// Single 4-bit adder slice with carry in/out, time-shared by the sequencer.
module add4_ci
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                ci_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                co_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, ci_i};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract computed LS nibble first through one 4-bit slice,
// with the carry registered between slices and a valid/ready on each side.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operation
//   RUN   | one nibble slice per cycle, count 0..NIBBLES-1
//   DONE  | out_valid=1, result held until out_ready
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = NIBBLE_W * NIBBLES,
  localparam int CNT_W   = $clog2(NIBBLES) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    a_sr_q, a_sr_d;
  logic [WIDTH-1:0]    b_sr_q, b_sr_d;
  logic [WIDTH-1:0]    sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic [NIBBLE_W-1:0]       slice_s;
  logic                      slice_co;
  logic [WIDTH+NIBBLE_W-1:0] sum_cat;
  logic [WIDTH-1:0]          sum_shift;
  logic                      last_slice;

  add4_ci u_add4_ci (
    .a_i  (a_sr_q[NIBBLE_W-1:0]),
    .b_i  (b_sr_q[NIBBLE_W-1:0]),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  // New slice enters at the top so the LS nibble ends at bit 0 after NIBBLES shifts.
  assign sum_cat    = {slice_s, sum_sr_q};
  assign sum_shift  = WIDTH'(sum_cat >> NIBBLE_W);
  assign last_slice = (cnt_q == CNT_W'(NIBBLES - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sr_d  = op_a;
          b_sr_d  = sub ? ~op_b : op_b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sr_d   = a_sr_q >> NIBBLE_W;
        b_sr_d   = b_sr_q >> NIBBLE_W;
        sum_sr_d = sum_shift;
        carry_d  = slice_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_slice) begin
          // Result lives in its own registers so it survives the next operation's RUN.
          sum_d   = sum_shift;
          cout_d  = slice_co;
          ovf_d   = (a_sr_q[NIBBLE_W-1] == b_sr_q[NIBBLE_W-1]) &&
                    (slice_s[NIBBLE_W-1] != a_sr_q[NIBBLE_W-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: directed corner cases,
// backpressure, reset abort, and randomized back-to-back traffic vs an arithmetic model.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         in_ready, out_valid, busy, carry_out, overflow;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_pass   = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain signed/unsigned integer arithmetic, returns {overflow, carry_out, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    longint ua, ub, sa, sb, r, hi, lo;
    logic ovf, cout;
    logic [W-1:0] sm;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    r  = s ? sa - sb : sa + sb;
    ovf  = (r > hi) || (r < lo);
    cout = s ? (ua >= ub) : ((ua + ub) >= (longint'(1) << W));
    sm   = W'(s ? ua - ub : ua + ub);
    return {ovf, cout, sm};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = '1;
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = {1'b1, {(W-1){1'b0}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Issue one op from IDLE and wait for out_valid; completes the handshake if out_ready=1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W+1:0] got, output int lat);
    int g;
    op_a = a;
    op_b = b;
    sub = s;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {overflow, carry_out, sum};
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, out_valid, busy, carry_out, overflow, sum} !== {5'b10000, {W{1'b0}}})
      $display("FAIL reset_values: got rdy=%b vld=%b busy=%b co=%b ovf=%b sum=%h, need 1 0 0 0 0 0",
               in_ready, out_valid, busy, carry_out, overflow, sum);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
    logic [W-1:0] tb [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h4321};
    logic         ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W+1:0] te [6] = '{{2'b00, 16'h0002}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                             {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}, {2'b00, 16'h5555}};
    logic [W+1:0] got;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], ts[i], got, lat);
      n_checks++;
      if (lat !== NIBBLES) $display("FAIL directed_latency[%0d]: got %0d need %0d", i, lat, NIBBLES);
      else n_pass++;
      n_checks++;
      if (got !== te[i])
        $display("FAIL directed_result[%0d]: got ovf,co,sum=%h need %h", i, got, te[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] got;
    int lat;
    out_ready = 1'b0;
    run_op(16'h0F0F, 16'h0101, 1'b0, got, lat);
    n_checks++;
    if (lat !== NIBBLES || got !== {2'b00, 16'h1010})
      $display("FAIL bp_result: got lat=%0d res=%h need lat=%0d res=%h", lat, got, NIBBLES, {2'b00, 16'h1010});
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({out_valid, in_ready, sum} !== {2'b10, 16'h1010})
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b sum=%h need 1 0 1010", i, out_valid, in_ready, sum);
      else n_pass++;
      if (i == 3) begin
        op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
      end
      if (i == 6) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, busy, sum} !== {3'b100, 16'h1010})
      $display("FAIL bp_release: got rdy=%b vld=%b busy=%b sum=%h need 1 0 0 1010", in_ready, out_valid, busy, sum);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL bp_ignored_req: got busy=%b need 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic [W+1:0] got;
    int lat;
    out_ready = 1'b1;
    op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, carry_out, overflow, sum} !== {5'b10000, {W{1'b0}}})
      $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b co=%b ovf=%b sum=%h, need 1 0 0 0 0 0",
               in_ready, out_valid, busy, carry_out, overflow, sum);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL midrun_no_valid[%0d]: got %b need 0", i, out_valid);
      else n_pass++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h1234, 16'h4321, 1'b0, got, lat);
    n_checks++;
    if (lat !== NIBBLES || got !== {2'b00, 16'h5555})
      $display("FAIL post_reset_op: got lat=%0d res=%h need lat=%0d res=%h", lat, got, NIBBLES, {2'b00, 16'h5555});
    else n_pass++;
  endtask

  task automatic test_back_to_back(input int n_ops);
    logic [W+1:0] q[$];
    logic [W+1:0] exp_r;
    int issued, done, cyc, last_acc;
    bit acc, cons, first;
    issued = 0; done = 0; cyc = 0; last_acc = 0; first = 1'b1;
    out_ready = 1'b1;
    op_a = rnd_operand(); op_b = rnd_operand(); sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    while (done < n_ops && cyc < n_ops * 40) begin
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL b2b_unexpected_result: got sum=%h need no output", sum);
        end else begin
          exp_r = q.pop_front();
          if ({overflow, carry_out, sum} !== exp_r)
            $display("FAIL b2b_result[%0d]: got ovf,co,sum=%h need %h", done, {overflow, carry_out, sum}, exp_r);
          else n_pass++;
        end
        done++;
      end
      if (acc) begin
        q.push_back(model(op_a, op_b, sub));
        issued++;
        if (!first) begin
          n_checks++;
          if (cyc - last_acc < NIBBLES + 2)
            $display("FAIL b2b_interval: got %0d need >= %0d", cyc - last_acc, NIBBLES + 2);
          else n_pass++;
        end
        first = 1'b0;
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (issued < n_ops) begin
          op_a = rnd_operand(); op_b = rnd_operand(); sub = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (done !== n_ops) $display("FAIL b2b_completed: got %0d results need %0d", done, n_ops);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back(1000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-sharing one 4-bit adder slice across NIBBLES cycles, least-significant nibble first, with a registered carry chained between slices. It sits between a requester (valid/ready) and a consumer (valid/ready). It trades latency for area wherever a wide adder is too costly. It owns operand shift registers, the carry register, the nibble counter and the control FSM.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width WIDTH = 4*NIBBLES (legal range 1..16)
CNT_W, $clog2(NIBBLES)+1, nibble counter width (derived, not overridden)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op present
in_ready  output  1  block can accept an operation
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
sub  input  1  0: A+B, 1: A-B (two's complement)
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
carry_out  output  1  final carry; for sub, 1 = no borrow
overflow  output  1  signed overflow of the operation
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE. in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, busy=0. Counter, shift registers and carry register are all 0.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch op_a into a_sr. Latch (sub ? ~op_b : op_b) into b_sr. Set carry reg = sub. Clear count. Latch sub_q. Go to RUN.
- RUN: one slice per cycle.
  - Slice inputs: a_sr[3:0], b_sr[3:0], carry reg.
  - 4-bit result shifts into sum_sr from the top; a_sr and b_sr shift right by 4.
  - Slice carry-out goes to the carry reg.
  - On the last slice (count==NIBBLES-1), register the overflow term: (a_msb == b'_msb) && (s_msb != a_msb). Here b'_msb is the post-invert B MSB. Then go to DONE.
- DONE:
  - out_valid=1. sum, carry_out and overflow are stable and driven from registers.
  - On out_ready go to IDLE. out_valid drops the next cycle.
  - out_valid is held with outputs unchanged for any duration of out_ready=0.
- Latency: accept at edge k → out_valid high after edge k+NIBBLES. Minimum issue interval NIBBLES+2 cycles.
- in_ready is 1 only in IDLE. in_valid in RUN/DONE is ignored; the requester holds.
- sum/carry_out/overflow retain the last result after leaving DONE. They are only meaningful while out_valid=1.
- A reset asserted mid-RUN or mid-DONE aborts the operation immediately. No partial result is output; return is to the reset values.
- Width rules:
  - sum wraps modulo 2^WIDTH.
  - For sub, carry_out = NOT borrow.
  - For NIBBLES=1, RUN lasts exactly one cycle.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NIBBLE_W=4 constant.
- Sub-module: add4_ci. It is combinational and computes {co, s[3:0]} = a[3:0] + b[3:0] + ci. It is instantiated once.
- The FSM, counter and shift registers stay in the top.

Test Plan:
1. NIBBLES=4; A=0x0001, B=0x0001, sub=0, out_ready=1 → sum=0x0002, carry_out=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge.
2. A=0xFFFF, B=0x0001, add → sum=0x0000, carry_out=1, overflow=0. A=0x7FFF, B=0x0001 → sum=0x8000, carry_out=0, overflow=1.
3. Subtract, A=0x0005, B=0x0007 → sum=0xFFFE, carry_out=0 (borrow), overflow=0. A=0x8000, B=0x0001 → sum=0x7FFF, carry_out=1, overflow=1.
4. Backpressure: out_ready=0 for 10 cycles in DONE → out_valid and sum are held constant and in_ready=0. A new in_valid pulse is not accepted. After out_ready=1, return to IDLE and in_ready=1 the next cycle.
5. Reset mid-op: drop rst_n 2 cycles into RUN → outputs are immediately at reset values, with no out_valid. A fresh op 0x1234+0x4321 after release gives sum=0x5555.
6. Back-to-back random ops (≥1000, both sub values), checked against a WIDTH-bit reference model. The issue interval is never less than NIBBLES+2 cycles.
